// File: rtl/pc_sequencer_if.sv
// Signal bundle between the sequencer and its PC unit, instruction memory,
// execute stage and interrupt source.
interface pc_sequencer_if;
  logic [31:0] pc;
  logic [1:0]  pc_op;
  logic [31:0] pc_next;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        int_return;
  logic        int_req;
  logic        int_ack;
  logic [31:0] epc;

  modport master (
    input  pc, mem_ready, mem_data, exec_done, branch_taken, branch_target,
           int_return, int_req,
    output pc_op, pc_next, mem_req, mem_addr, instr, instr_valid, int_ack, epc
  );

  modport slave (
    output pc, mem_ready, mem_data, exec_done, branch_taken, branch_target,
           int_return, int_req,
    input  pc_op, pc_next, mem_req, mem_addr, instr, instr_valid, int_ack, epc
  );
endinterface

// File: rtl/pc_sequencer.sv
// Moore FSM sequencing fetch, execute and PC update for the pc unit, with
// interrupt entry at instruction boundaries and a saved return address.
module pc_sequencer #(
  parameter logic [31:0] INT_VECTOR = 32'h0000_0010
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.master bus
);

  localparam logic [2:0] S_RST    = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_TRAP   = 3'd4;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_INC    = 2'b01;
  localparam logic [1:0] OP_ASSIGN = 2'b10;
  localparam logic [1:0] OP_RESET  = 2'b11;

  logic [2:0]  r_state;
  logic [31:0] r_instr;
  logic [31:0] r_epc;
  logic        r_int_pending;
  logic        r_int_en;
  logic [1:0]  r_upd_op;
  logic [31:0] r_upd_next;

  logic [1:0]  w_pc_op;
  logic [31:0] w_pc_next;
  logic        w_mem_req;
  logic        w_instr_valid;
  logic        w_int_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_RST;
      r_instr       <= '0;
      r_epc         <= '0;
      r_int_pending <= 1'b0;
      r_int_en      <= 1'b1;
      r_upd_op      <= OP_NOP;
      r_upd_next    <= '0;
    end else begin
      // Requests landing in TRAP are dropped; the TRAP branch below clears.
      if (bus.int_req && r_state != S_TRAP)
        r_int_pending <= 1'b1;

      case (r_state)
        S_RST: r_state <= S_FETCH;
        S_FETCH: begin
          if (bus.mem_ready) begin
            r_instr <= bus.mem_data;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (bus.exec_done) begin
            if (bus.int_return) begin
              r_upd_op   <= OP_ASSIGN;
              r_upd_next <= r_epc;
              r_int_en   <= 1'b1;
            end else if (bus.branch_taken) begin
              r_upd_op   <= OP_ASSIGN;
              r_upd_next <= {bus.branch_target[31:2], 2'b00};
            end else begin
              r_upd_op   <= OP_INC;
              r_upd_next <= '0;
            end
            r_state <= S_UPDATE;
          end
        end
        S_UPDATE: r_state <= (r_int_pending && r_int_en) ? S_TRAP : S_FETCH;
        S_TRAP: begin
          // PC unit has already applied the UPDATE, so pc is the return point.
          r_epc         <= bus.pc;
          r_int_pending <= 1'b0;
          r_int_en      <= 1'b0;
          r_state       <= S_FETCH;
        end
        default: r_state <= S_RST;
      endcase
    end
  end

  always_comb begin
    w_pc_op       = OP_NOP;
    w_pc_next     = '0;
    w_mem_req     = 1'b0;
    w_instr_valid = 1'b0;
    w_int_ack     = 1'b0;
    case (r_state)
      S_RST:    w_pc_op = OP_RESET;
      S_FETCH:  w_mem_req = 1'b1;
      S_EXEC:   w_instr_valid = 1'b1;
      S_UPDATE: begin
        w_pc_op   = r_upd_op;
        w_pc_next = r_upd_next;
      end
      S_TRAP: begin
        w_pc_op   = OP_ASSIGN;
        w_pc_next = INT_VECTOR;
        w_int_ack = 1'b1;
      end
      default: w_pc_op = OP_RESET;
    endcase
  end

  assign bus.pc_op       = w_pc_op;
  assign bus.pc_next     = w_pc_next;
  assign bus.mem_req     = w_mem_req;
  assign bus.mem_addr    = bus.pc;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = w_instr_valid;
  assign bus.int_ack     = w_int_ack;
  assign bus.epc         = r_epc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: walks instructions at transaction level
// and predicts PC flow, epc and interrupt entry from the architectural rules.
module tb_pc_sequencer;
  localparam logic [31:0] INT_VEC = 32'h0000_0010;

  logic clk = 1'b0;
  logic reset = 1'b1;
  pc_sequencer_if bus();

  pc_sequencer #(.INT_VECTOR(INT_VEC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // PC unit behaviour the sequencer drives.
  logic [31:0] r_pc_unit = 32'hDEAD_BEE0;
  always @(posedge clk) begin
    case (bus.pc_op)
      2'b11: r_pc_unit <= 32'h0;
      2'b01: r_pc_unit <= r_pc_unit + 32'd4;
      2'b10: r_pc_unit <= bus.pc_next;
      default: ;
    endcase
  end
  assign bus.pc = r_pc_unit;

  int n_chk  = 0;
  int n_pass = 0;
  int irq_pct = 0;

  logic [31:0] m_pc, m_epc;
  bit          m_pend, m_en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit rnd_irq();
    return ($urandom_range(99) < irq_pct);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_pend = 1'b0; m_en = 1'b1;
  endtask

  // One instruction starting in its first FETCH cycle. kind: 0 inc, 1 branch, 2 return.
  task automatic run_instr(input int fd, input int ed, input int kind,
                           input logic [31:0] tgt, input bit irq_in_exec);
    logic [31:0] data, enext;
    logic [1:0]  eop;
    bit          take;
    data = 32'h0;
    for (int k = 0; k <= fd; k++) begin
      chk("fetch_req",   32'(bus.mem_req), 1);
      chk("fetch_addr",  bus.mem_addr, m_pc);
      chk("fetch_op",    32'(bus.pc_op), 0);
      chk("fetch_valid", 32'(bus.instr_valid), 0);
      chk("fetch_ack",   32'(bus.int_ack), 0);
      chk("fetch_epc",   bus.epc, m_epc);
      data              = $urandom;
      bus.mem_data      = data;
      bus.mem_ready     = (k == fd);
      bus.exec_done     = 1'($urandom_range(1));
      bus.int_return    = 1'($urandom_range(1));
      bus.branch_taken  = 1'($urandom_range(1));
      bus.branch_target = $urandom;
      bus.int_req       = rnd_irq();
      if (bus.int_req) m_pend = 1'b1;
      step();
    end
    for (int k = 0; k <= ed; k++) begin
      chk("exec_valid", 32'(bus.instr_valid), 1);
      chk("exec_instr", bus.instr, data);
      chk("exec_req",   32'(bus.mem_req), 0);
      chk("exec_op",    32'(bus.pc_op), 0);
      chk("exec_next",  bus.pc_next, 0);
      bus.mem_ready = 1'($urandom_range(1));
      bus.mem_data  = $urandom;
      bus.exec_done = (k == ed);
      if (k == ed) begin
        bus.int_return    = (kind == 2);
        bus.branch_taken  = (kind == 1) || (kind == 2 && $urandom_range(1) == 1);
        bus.branch_target = (kind == 1) ? tgt : $urandom;
      end else begin
        bus.int_return    = 1'($urandom_range(1));
        bus.branch_taken  = 1'($urandom_range(1));
        bus.branch_target = $urandom;
      end
      bus.int_req = (irq_in_exec && k == 0) || rnd_irq();
      if (bus.int_req) m_pend = 1'b1;
      step();
    end
    if (kind == 2) begin
      eop = 2'b10; enext = m_epc; m_en = 1'b1;
    end else if (kind == 1) begin
      eop = 2'b10; enext = {tgt[31:2], 2'b00};
    end else begin
      eop = 2'b01; enext = 32'h0;
    end
    chk("upd_op",    32'(bus.pc_op), 32'(eop));
    chk("upd_next",  bus.pc_next, enext);
    chk("upd_req",   32'(bus.mem_req), 0);
    chk("upd_valid", 32'(bus.instr_valid), 0);
    chk("upd_ack",   32'(bus.int_ack), 0);
    take = m_pend && m_en;
    bus.exec_done    = 1'($urandom_range(1));
    bus.int_return   = 1'($urandom_range(1));
    bus.branch_taken = 1'($urandom_range(1));
    bus.mem_ready    = 1'($urandom_range(1));
    bus.int_req      = rnd_irq();
    if (bus.int_req) m_pend = 1'b1;
    m_pc = (eop == 2'b01) ? m_pc + 32'd4 : enext;
    step();
    if (take) begin
      chk("trap_ack",  32'(bus.int_ack), 1);
      chk("trap_op",   32'(bus.pc_op), 2);
      chk("trap_next", bus.pc_next, INT_VEC);
      chk("trap_req",  32'(bus.mem_req), 0);
      bus.exec_done = 1'($urandom_range(1));
      bus.int_req   = rnd_irq();
      step();
      m_epc = m_pc; m_pc = INT_VEC; m_pend = 1'b0; m_en = 1'b0;
    end
    bus.exec_done = 1'b0; bus.int_return = 1'b0; bus.branch_taken = 1'b0;
    bus.mem_ready = 1'b0; bus.int_req = 1'b0;
  endtask

  // Called in a FETCH cycle: reset there, then a stray ready in the RST cycle.
  task automatic reset_mid_fetch();
    chk("mrst_pre_req", 32'(bus.mem_req), 1);
    reset = 1'b1; bus.mem_ready = 1'b0; bus.int_req = 1'b1;
    step();
    chk("mrst_req", 32'(bus.mem_req), 0);
    chk("mrst_op",  32'(bus.pc_op), 3);
    chk("mrst_epc", bus.epc, 0);
    chk("mrst_valid", 32'(bus.instr_valid), 0);
    reset = 1'b0; bus.int_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_data = $urandom;
    chk("mrst_rel_op",  32'(bus.pc_op), 3);
    chk("mrst_rel_req", 32'(bus.mem_req), 0);
    step();
    bus.mem_ready = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.mem_ready = 1'b0; bus.mem_data = 32'h0; bus.exec_done = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_target = 32'h0; bus.int_return = 1'b0;
    bus.int_req = 1'b1;
    reset = 1'b1;
    step(); step();
    chk("rst_op",    32'(bus.pc_op), 3);
    chk("rst_req",   32'(bus.mem_req), 0);
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_ack",   32'(bus.int_ack), 0);
    chk("rst_epc",   bus.epc, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_next",  bus.pc_next, 0);
    reset = 1'b0; bus.int_req = 1'b0;
    chk("rel_op",  32'(bus.pc_op), 3);
    chk("rel_req", 32'(bus.mem_req), 0);
    step();
    model_reset();

    // Back-to-back sequential flow, interrupt at PC 0x8, nested pulse in handler.
    run_instr(0, 0, 0, 32'h0, 1'b0);
    run_instr(0, 0, 0, 32'h0, 1'b0);
    run_instr(0, 0, 0, 32'h0, 1'b1);
    chk("irq_epc", bus.epc, 32'hC);
    run_instr(0, 0, 0, 32'h0, 1'b1);
    run_instr(0, 0, 2, 32'h0, 1'b0);
    run_instr(0, 0, 2, 32'h0, 1'b0);
    // Delayed ready, branch alignment, wrap at top of address space.
    run_instr(3, 0, 0, 32'h0, 1'b0);
    run_instr(0, 1, 1, 32'h0000_0123, 1'b0);
    run_instr(0, 0, 1, 32'hFFFF_FFFF, 1'b0);
    run_instr(0, 0, 0, 32'h0, 1'b0);
    run_instr(1, 2, 0, 32'h0, 1'b0);
    reset_mid_fetch();
    run_instr(0, 0, 0, 32'h0, 1'b0);

    irq_pct = 12;
    for (int i = 0; i < 250; i++) begin
      int r;
      r = int'($urandom_range(9));
      run_instr(int'($urandom_range(3)), int'($urandom_range(3)),
                (r == 0) ? 2 : (r < 4) ? 1 : 0, $urandom, 1'b0);
      if (i == 120) reset_mid_fetch();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
